dmem_store_buffer: RTL
======================

Name: dmem_store_buffer

Overview:
- Sits between the core data-memory port and the data RAM/bus.
- Stores are written into a DEPTH-entry FIFO and drained in order to a ready/valid write port. Loads pass straight through to the combinational read port.
- Read data is merged byte-wise with any pending buffered stores to the same word (store-to-load forwarding), so the core always sees program-ordered data.
- `full_o` gives the pipeline a stall hook.

Parameters:
- XLEN, 32, data/address width.
- DEPTH, 4, number of buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- adr_v_i  in  1  core access valid this cycle.
- adr_i  in  XLEN  core byte address.
- is_store_i  in  1  1 = store, 0 = load.
- store_data_i  in  XLEN  store data, right-aligned (LSB = first byte).
- access_size_i  in  3  0 = byte, 1 = half, 2 = word; any other value is illegal.
- load_data_o  out  XLEN  aligned word at adr_i[XLEN-1:2], forwarded bytes merged; combinational.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- misalign_o  out  1  pulse: current access misaligned or has an illegal size; combinational.
- overflow_o  out  1  sticky: a store was dropped because the buffer was full.
- rd_adr_o  out  XLEN  word-aligned read address to RAM = {adr_i[XLEN-1:2], 2'b00}.
- rd_data_i  in  XLEN  RAM read data, same cycle.
- wr_v_o  out  1  head entry valid for drain.
- wr_adr_o  out  XLEN  head word address.
- wr_data_o  out  XLEN  head data, lane-positioned.
- wr_be_o  out  4  head byte enables.
- wr_ready_i  in  1  RAM accepts the write when wr_v_o && wr_ready_i.

Behaviour:
- Entry fields: {wadr[XLEN-3:0], data[31:0], be[3:0]}. Pointers are wr_ptr and rd_ptr, log2(DEPTH) bits each, and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset: pointers and count go to 0, overflow_o goes to 0. Entry contents are don't-care. On the cycle after reset, wr_v_o = 0, empty_o = 1, full_o = 0.
- Alignment:
  - Misaligned when size = half and adr_i[0] = 1, or size = word and adr_i[1:0] != 0, or size > 2.
  - A misaligned access sets misalign_o for that cycle. It is not enqueued and does not alter state. load_data_o is still driven.
- Store lane formatting:
  - data = store_data_i << (8*adr_i[1:0]).
  - be = 4'b0001 / 4'b0011 / 4'b1111 << adr_i[1:0], for byte / half / word.
- Enqueue: adr_v_i && is_store_i && aligned && (!full || drain this cycle) → write the entry at wr_ptr and advance wr_ptr.
- Coalescing:
  - Applies when the youngest entry has the same wadr and the youngest entry is not the one draining this cycle.
  - The new bytes are merged into that entry (data replaced where the new be = 1; be OR'd). The pointer does not advance.
  - Coalescing is allowed even when the buffer is full.
- Drop: a store with full && !drain && no coalesce sets overflow_o = 1, which stays set until reset. The buffer is unchanged.
- Drain:
  - wr_v_o = !empty. wr_adr_o = {wadr, 2'b00}.
  - When wr_v_o && wr_ready_i, advance rd_ptr. Entries retire strictly in FIFO order.
- Count update: count_next = count + enq − drain. Simultaneous enqueue and drain keeps the count. Enqueue and drain can both happen while full; that case is legal and keeps full.
- Forwarding (loads, and also stores, for which the value is unused):
  - For each byte lane, walk the valid entries oldest → youngest. The youngest entry with a matching wadr and be[lane] = 1 supplies the byte; otherwise the lane comes from rd_data_i.
  - An entry draining this cycle still forwards.
- Latency:
  - Stores are visible to forwarding on the cycle after enqueue.
  - A store reaches the RAM no earlier than 1 cycle after enqueue, and later by the number of preceding entries and ready stalls.
- Reset mid-drain: a synchronous reset discards all pending entries. No write is issued after the reset edge.

Test Plan:
- Reset, then an SW of 0xDEADBEEF to 0x100 with wr_ready_i = 1 → the next cycle wr_v_o = 1, wr_adr_o = 0x100, wr_data_o = 0xDEADBEEF, wr_be_o = 4'b1111. The cycle after that, empty_o = 1.
- wr_ready_i = 0. SB 0xAA to 0x201, then an LW of 0x200 with rd_data_i = 0x11223344 → load_data_o = 0x1122AA44, and the buffer holds 1 entry.
- wr_ready_i = 0. SH 0xBEEF to 0x302, then SB 0x55 to 0x300 (coalesce) → a single entry with be = 4'b1101 and data = 0xBEEFxx55. count stays 1.
- wr_ready_i = 0. Four SW to distinct words → full_o = 1. A fifth SW to a new word → overflow_o = 1 and count = 4. Raising wr_ready_i drains the four writes in order.
- Full buffer with wr_ready_i = 1 and a simultaneous SW to a new word → accepted, and full_o stays 1.
- SH to 0x103 → misalign_o = 1 for one cycle, no enqueue, empty_o stays 1. Asserting reset while 3 entries are pending → wr_v_o = 0 the next cycle.

Source files
------------

// File: rtl/dmem_store_buffer_if.sv
// Core-side and RAM-side signals of the data-memory store buffer.
// The buffer connects through the slave modport; the core/RAM side uses master.
interface dmem_store_buffer_if #(
    parameter int XLEN = 32
);
    logic            adr_v_i;
    logic [XLEN-1:0] adr_i;
    logic            is_store_i;
    logic [XLEN-1:0] store_data_i;
    logic [2:0]      access_size_i;
    logic [XLEN-1:0] load_data_o;
    logic            full_o;
    logic            empty_o;
    logic            misalign_o;
    logic            overflow_o;
    logic [XLEN-1:0] rd_adr_o;
    logic [XLEN-1:0] rd_data_i;
    logic            wr_v_o;
    logic [XLEN-1:0] wr_adr_o;
    logic [XLEN-1:0] wr_data_o;
    logic [3:0]      wr_be_o;
    logic            wr_ready_i;

    modport slave (
        input  adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
               rd_data_i, wr_ready_i,
        output load_data_o, full_o, empty_o, misalign_o, overflow_o,
               rd_adr_o, wr_v_o, wr_adr_o, wr_data_o, wr_be_o
    );

    modport master (
        output adr_v_i, adr_i, is_store_i, store_data_i, access_size_i,
               rd_data_i, wr_ready_i,
        input  load_data_o, full_o, empty_o, misalign_o, overflow_o,
               rd_adr_o, wr_v_o, wr_adr_o, wr_data_o, wr_be_o
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// In-order store buffer with write coalescing into the youngest entry and
// byte-wise store-to-load forwarding onto the combinational RAM read path.
module dmem_store_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                reset,
    dmem_store_buffer_if.slave sb
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = XLEN - 2;

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          overflow_reg;

    logic [AW-1:0] wadr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [3:0]    be_mem   [DEPTH];

    logic [1:0]    off;
    logic [AW-1:0] acc_wadr;
    logic          misalign;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic          full;
    logic          empty;
    logic          drain;
    logic          store_ok;
    logic          coalesce;
    logic          enq;
    logic          drop;
    logic [PW-1:0] young_ptr;

    assign off      = sb.adr_i[1:0];
    assign acc_wadr = sb.adr_i[XLEN-1:2];
    assign st_data  = sb.store_data_i[31:0] << {off, 3'b000};

    always_comb begin
        st_be    = 4'b0000;
        misalign = 1'b0;
        case (sb.access_size_i)
            3'd0: st_be = 4'b0001 << off;
            3'd1: begin
                st_be    = 4'b0011 << off;
                misalign = off[0];
            end
            3'd2: begin
                st_be    = 4'b1111 << off;
                misalign = (off != 2'b00);
            end
            default: misalign = 1'b1;
        endcase
    end

    assign full      = (count_reg == (PW+1)'(DEPTH));
    assign empty     = (count_reg == '0);
    assign drain     = !empty && sb.wr_ready_i;
    assign young_ptr = wr_ptr_reg - PW'(1);
    assign store_ok  = sb.adr_v_i && sb.is_store_i && !misalign;

    // When only one entry is held and it drains now, it is both head and youngest,
    // so a matching store must open a fresh entry instead of merging.
    assign coalesce = store_ok && !empty && (wadr_mem[young_ptr] == acc_wadr)
                      && !(drain && count_reg == (PW+1)'(1));
    assign enq      = store_ok && !coalesce && (!full || drain);
    assign drop     = store_ok && !coalesce && full && !drain;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (drain) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg <= count_reg + (PW+1)'(enq) - (PW+1)'(drain);
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Entry payload carries no reset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            wadr_mem[wr_ptr_reg] <= acc_wadr;
            data_mem[wr_ptr_reg] <= st_data;
            be_mem[wr_ptr_reg]   <= st_be;
        end else if (coalesce) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    data_mem[young_ptr][8*b +: 8] <= st_data[8*b +: 8];
                end
            end
            be_mem[young_ptr] <= be_mem[young_ptr] | st_be;
        end
    end

    // Each lane scans oldest to youngest so the youngest matching byte wins.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0]    lane_byte;
            logic [PW-1:0] idx;
            always_comb begin
                lane_byte = sb.rd_data_i[8*gi +: 8];
                idx       = rd_ptr_reg;
                for (int k = 0; k < DEPTH; k++) begin
                    idx = rd_ptr_reg + PW'(k);
                    if (((PW+1)'(k) < count_reg) && (wadr_mem[idx] == acc_wadr)
                            && be_mem[idx][gi]) begin
                        lane_byte = data_mem[idx][8*gi +: 8];
                    end
                end
            end
            assign sb.load_data_o[8*gi +: 8] = lane_byte;
        end
        if (XLEN > 32) begin : g_wide
            assign sb.load_data_o[XLEN-1:32] = sb.rd_data_i[XLEN-1:32];
        end
    endgenerate

    assign sb.full_o     = full;
    assign sb.empty_o    = empty;
    assign sb.misalign_o = sb.adr_v_i && misalign;
    assign sb.overflow_o = overflow_reg;
    assign sb.rd_adr_o   = {sb.adr_i[XLEN-1:2], 2'b00};
    assign sb.wr_v_o     = !empty;
    assign sb.wr_adr_o   = {wadr_mem[rd_ptr_reg], 2'b00};
    assign sb.wr_data_o  = XLEN'(data_mem[rd_ptr_reg]);
    assign sb.wr_be_o    = be_mem[rd_ptr_reg];
endmodule
